me_sad_accumulator: RTL and testbench

- Upstream stage of the block-matching comparator.
- Streams current-block and reference-candidate pixels, computes the 16x16 sum of absolute differences (SAD) for each candidate position, and emits one {SAD, position} result per candidate.
- Its result strobe drives the comparator's start16/inSAD41/position16 inputs.
- Sequences all NUM_POS candidates of one search, then signals completion.

---
 rtl/me_pkg.sv | 22 ++
 rtl/me_absdiff_sum.sv | 28 ++
 rtl/me_sad_accumulator.sv | 231 +++++++++++++++++++++++
 tb/tb_me_sad_accumulator.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared constants and types for the motion-estimation SAD datapath.
package me_pkg;

    localparam int BLOCK_PIX = 256;
    localparam int PIX_W     = 8;
    localparam int SAD_W     = 16;
    localparam int POS_W     = 10;

    localparam logic [SAD_W-1:0] SAD_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } me_state_e;

    // Width of a per-beat lane sum: one pixel plus log2(lanes) carry bits.
    function automatic int beat_sum_width(input int lanes);
        return PIX_W + $clog2(lanes);
    endfunction

endpackage

// File: rtl/me_absdiff_sum.sv
// Combinational per-beat sum of |cur - ref| over all pixel lanes.
module me_absdiff_sum
    import me_pkg::*;
#(
    parameter int LANES = 4,
    parameter int SUM_W = beat_sum_width(LANES)
) (
    input  logic [PIX_W*LANES-1:0] cur_pix,
    input  logic [PIX_W*LANES-1:0] ref_pix,
    output logic [SUM_W-1:0]       beat_sum
);

    logic [PIX_W-1:0] a_v;
    logic [PIX_W-1:0] b_v;

    // Lane-wise absolute difference folded into a single sum.
    always_comb begin
        beat_sum = '0;
        a_v      = '0;
        b_v      = '0;
        for (int i = 0; i < LANES; i++) begin
            a_v      = cur_pix[i*PIX_W +: PIX_W];
            b_v      = ref_pix[i*PIX_W +: PIX_W];
            beat_sum = beat_sum + SUM_W'((a_v > b_v) ? (a_v - b_v) : (b_v - a_v));
        end
    end

endmodule

// File: rtl/me_sad_accumulator.sv
// 16x16 SAD accumulator: sequences NUM_POS candidates, emits one
// {SAD, position} strobe per candidate, then pulses search_done.
// Optional build macro ME_EARLY_TERMINATE_EN: candidates whose partial
// SAD reaches best_sad stop accumulating and report SAD_MAX.
//
// state | meaning
// IDLE  | waiting for search_start
// RUN   | accepting beats, counting beat/pos
// DRAIN | last beat accepted, waiting for the pipeline to empty
module me_sad_accumulator
    import me_pkg::*;
#(
    parameter int PIX_PER_CYCLE = 4,
    parameter int NUM_POS       = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           search_start,
    input  logic                           in_valid,
    input  logic [PIX_W*PIX_PER_CYCLE-1:0] cur_pix,
    input  logic [PIX_W*PIX_PER_CYCLE-1:0] ref_pix,
    input  logic [SAD_W-1:0]               best_sad,
    output logic                           sad_valid,
    output logic [SAD_W-1:0]               sad_out,
    output logic [POS_W-1:0]               sad_position,
    output logic                           busy,
    output logic                           search_done
);

    localparam int BEATS  = BLOCK_PIX / PIX_PER_CYCLE;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SUM_W  = beat_sum_width(PIX_PER_CYCLE);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [POS_W-1:0]  LAST_POS  = POS_W'(NUM_POS - 1);

    me_state_e          state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               s1_valid_q, s1_valid_d;
    logic [SUM_W-1:0]   s1_sum_q, s1_sum_d;
    logic               s1_first_q, s1_first_d;
    logic               s1_last_q, s1_last_d;
    logic [POS_W-1:0]   s1_pos_q, s1_pos_d;

    logic [SAD_W-1:0]   acc_q, acc_d;
    logic               s2_done_q, s2_done_d;
    logic [POS_W-1:0]   s2_pos_q, s2_pos_d;

    logic               sad_valid_q, sad_valid_d;
    logic [SAD_W-1:0]   sad_out_q, sad_out_d;
    logic [POS_W-1:0]   sad_position_q, sad_position_d;

    logic [SUM_W-1:0]   beat_sum;
    logic               accept;

`ifdef ME_EARLY_TERMINATE_EN
    logic               rej_q, rej_d;
`else
    logic               unused_best_sad;
    assign unused_best_sad = ^best_sad;
`endif

    assign accept = (state_q == RUN) && in_valid && !clear;

    me_absdiff_sum #(
        .LANES (PIX_PER_CYCLE),
        .SUM_W (SUM_W)
    ) u_absdiff_sum (
        .cur_pix  (cur_pix),
        .ref_pix  (ref_pix),
        .beat_sum (beat_sum)
    );

    // Next-state logic for the search sequencer and its beat/pos counters.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        pos_d   = pos_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (search_start) begin
                    state_d = RUN;
                    beat_d  = '0;
                    pos_d   = '0;
                end
            end
            RUN: begin
                if (in_valid) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        if (pos_q == LAST_POS) begin
                            pos_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            pos_d = pos_q + POS_W'(1);
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            DRAIN: begin
                // Stage-2 result for the last candidate is on its way out.
                if (!s1_valid_q && !s2_done_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d = IDLE;
            beat_d  = '0;
            pos_d   = '0;
            done_d  = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

    // Sequencer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            pos_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            pos_q   <= pos_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Datapath: stage-1 beat sum, stage-2 accumulate, registered result.
    always_comb begin
        s1_valid_d = accept;
        s1_sum_d   = s1_sum_q;
        s1_first_d = s1_first_q;
        s1_last_d  = s1_last_q;
        s1_pos_d   = s1_pos_q;
        if (accept) begin
            s1_sum_d   = beat_sum;
            s1_first_d = (beat_q == '0);
            s1_last_d  = (beat_q == LAST_BEAT);
            s1_pos_d   = pos_q;
        end

        acc_d     = acc_q;
        s2_done_d = s1_valid_q && s1_last_q && !clear;
        s2_pos_d  = s1_valid_q ? s1_pos_q : s2_pos_q;
`ifdef ME_EARLY_TERMINATE_EN
        rej_d = rej_q;
        if (s1_valid_q) begin
            if (s1_first_q) begin
                acc_d = SAD_W'(s1_sum_q);
                rej_d = (acc_d >= best_sad);
            end else if (!rej_q) begin
                acc_d = acc_q + SAD_W'(s1_sum_q);
                rej_d = (acc_d >= best_sad);
            end
        end
`else
        if (s1_valid_q) begin
            acc_d = s1_first_q ? SAD_W'(s1_sum_q) : (acc_q + SAD_W'(s1_sum_q));
        end
`endif

        sad_valid_d    = s2_done_q && !clear;
        sad_out_d      = sad_out_q;
        sad_position_d = sad_position_q;
        if (sad_valid_d) begin
`ifdef ME_EARLY_TERMINATE_EN
            sad_out_d = rej_q ? SAD_MAX : acc_q;
`else
            sad_out_d = acc_q;
`endif
            sad_position_d = s2_pos_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q     <= 1'b0;
            s1_sum_q       <= '0;
            s1_first_q     <= 1'b0;
            s1_last_q      <= 1'b0;
            s1_pos_q       <= '0;
            acc_q          <= '0;
            s2_done_q      <= 1'b0;
            s2_pos_q       <= '0;
            sad_valid_q    <= 1'b0;
            sad_out_q      <= '0;
            sad_position_q <= '0;
`ifdef ME_EARLY_TERMINATE_EN
            rej_q          <= 1'b0;
`endif
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_sum_q       <= s1_sum_d;
            s1_first_q     <= s1_first_d;
            s1_last_q      <= s1_last_d;
            s1_pos_q       <= s1_pos_d;
            acc_q          <= acc_d;
            s2_done_q      <= s2_done_d;
            s2_pos_q       <= s2_pos_d;
            sad_valid_q    <= sad_valid_d;
            sad_out_q      <= sad_out_d;
            sad_position_q <= sad_position_d;
`ifdef ME_EARLY_TERMINATE_EN
            rej_q          <= rej_d;
`endif
        end
    end

    assign sad_valid    = sad_valid_q;
    assign sad_out      = sad_out_q;
    assign sad_position = sad_position_q;
    assign busy         = busy_q;
    assign search_done  = done_q;

endmodule

// File: tb/tb_me_sad_accumulator.sv
// Scoreboard bench for me_sad_accumulator (4 lanes, 8 candidates).
module tb_me_sad_accumulator;

    localparam int PPC   = 4;
    localparam int NPOS  = 8;
    localparam int BEATS = 64;

    logic        clk = 1'b0;
    logic        reset, clear, search_start, in_valid;
    logic [31:0] cur_pix, ref_pix;
    logic [15:0] best_sad;
    logic        sad_valid, busy, search_done;
    logic [15:0] sad_out;
    logic [9:0]  sad_position;

    me_sad_accumulator #(.PIX_PER_CYCLE(PPC), .NUM_POS(NPOS)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .search_start (search_start),
        .in_valid     (in_valid),
        .cur_pix      (cur_pix),
        .ref_pix      (ref_pix),
        .best_sad     (best_sad),
        .sad_valid    (sad_valid),
        .sad_out      (sad_out),
        .sad_position (sad_position),
        .busy         (busy),
        .search_done  (search_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] sad;
        logic [9:0]  pos;
        int          edge_n;
    } exp_t;

    typedef struct {
        int id;
        int act;
        int exp;
    } chk_t;

    exp_t exp_q[$];
    chk_t chk_q[$];
    int   n_checks   = 0;
    int   n_pass     = 0;
    int   strobe_cnt = 0;
    int   last_edge  = 0;

    function automatic string chk_name(input int id);
        case (id)
            0:  return "rst_sad_valid";
            1:  return "rst_sad_out";
            2:  return "rst_sad_position";
            3:  return "rst_busy";
            4:  return "rst_search_done";
            5:  return "busy_after_start";
            6:  return "busy_before_done";
            7:  return "done_not_early";
            8:  return "search_done_pulse";
            9:  return "busy_with_done";
            10: return "done_one_cycle";
            11: return "busy_after_clear";
            12: return "strobes_after_clear";
            13: return "arst_sad_out";
            14: return "arst_busy";
            15: return "arst_sad_valid";
            16: return "arst_sad_position";
            17: return "busy_idle_after_arst";
            18: return "strobes_after_arst";
            19: return "pending_at_end";
            default: return "unknown";
        endcase
    endfunction

    task automatic chk(input int id, input int act, input int exp);
        chk_t c;
        c.id  = id;
        c.act = act;
        c.exp = exp;
        chk_q.push_back(c);
    endtask

    // Monitor: evaluates queued directed checks and scores every strobe.
    always @(negedge clk) begin
        chk_t c;
        exp_t e;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            n_checks++;
            if (c.act == c.exp) n_pass++;
            else $display("FAIL %s: got %0d expected %0d", chk_name(c.id), c.act, c.exp);
        end
        if (sad_valid) begin
            strobe_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_strobe: got sad=%0d pos=%0d expected none", sad_out, sad_position);
            end else begin
                e = exp_q.pop_front();
                n_checks += 3;
                if (sad_out == e.sad) n_pass++;
                else $display("FAIL sad_out: got %0d expected %0d (pos %0d)", sad_out, e.sad, e.pos);
                if (sad_position == e.pos) n_pass++;
                else $display("FAIL sad_position: got %0d expected %0d", sad_position, e.pos);
                if (cyc == e.edge_n) n_pass++;
                else $display("FAIL strobe_edge: got %0d expected %0d", cyc, e.edge_n);
            end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].edge_n) begin
            e = exp_q.pop_front();
            n_checks++;
            $display("FAIL missing_strobe: got none expected sad=%0d pos=%0d by edge %0d", e.sad, e.pos, e.edge_n);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        search_start = 1'b1;
        tick();
        search_start = 1'b0;
    endtask

    // Feed one full candidate; the strobe is expected two edges after the final beat.
    task automatic send_cand(input logic [31:0] c, input logic [31:0] r, input int pos,
                             input logic [15:0] exp_sad, input bit gaps, input int start_beat);
        exp_t e;
        for (int b = 0; b < BEATS; b++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 0) begin
                    in_valid = 1'b0;
                    cur_pix  = $urandom;
                    ref_pix  = $urandom;
                    tick();
                end
            end
            in_valid     = 1'b1;
            cur_pix      = c;
            ref_pix      = r;
            search_start = (b == start_beat);
            tick();
            in_valid     = 1'b0;
            search_start = 1'b0;
        end
        last_edge = cyc;
        e.sad     = exp_sad;
        e.pos     = 10'(pos);
        e.edge_n  = cyc + 2;
        exp_q.push_back(e);
    endtask

    logic [31:0] pat_c [8];
    logic [31:0] pat_r [8];
    logic [15:0] pat_s [8];

    initial begin
        // Hand-computed SADs: per-beat lane sum x 64 beats.
        pat_c[0] = 32'h0A0A0A0A; pat_r[0] = 32'h07070707; pat_s[0] = 16'd768;
        pat_c[1] = 32'h12345678; pat_r[1] = 32'h12345678; pat_s[1] = 16'd0;
        pat_c[2] = 32'hFFFFFFFF; pat_r[2] = 32'h00000000; pat_s[2] = 16'd65280;
        pat_c[3] = 32'h0A0A0A0A; pat_r[3] = 32'h07070707; pat_s[3] = 16'd768;
        pat_c[4] = 32'h01020304; pat_r[4] = 32'h04030201; pat_s[4] = 16'd512;
        pat_c[5] = 32'h00FF0010; pat_r[5] = 32'h10002010; pat_s[5] = 16'd19392;
        pat_c[6] = 32'h80808080; pat_r[6] = 32'h7F817F81; pat_s[6] = 16'd256;
        pat_c[7] = 32'h0A0A0A0A; pat_r[7] = 32'h00000000; pat_s[7] = 16'd2560;

        reset = 1'b1; clear = 1'b0; search_start = 1'b0; in_valid = 1'b0;
        cur_pix = '0; ref_pix = '0; best_sad = 16'hFFFF;
        repeat (3) tick();
        chk(0, int'(sad_valid), 0);
        chk(1, int'(sad_out), 0);
        chk(2, int'(sad_position), 0);
        chk(3, int'(busy), 0);
        chk(4, int'(search_done), 0);
        reset = 1'b0;
        tick();

        // Beats while IDLE must be ignored.
        in_valid = 1'b1; cur_pix = 32'hFFFFFFFF; ref_pix = '0;
        repeat (5) tick();
        in_valid = 1'b0;

        // Full search of 8 candidates; search_start mid-candidate 1 is ignored.
        pulse_start();
        chk(5, int'(busy), 1);
        for (int p = 0; p < NPOS; p++)
            send_cand(pat_c[p], pat_r[p], p, pat_s[p], (p == 3), (p == 1) ? 10 : -1);
        in_valid = 1'b1; cur_pix = 32'hFFFFFFFF; ref_pix = '0;
        tick();
        tick();
        chk(6, int'(busy), 1);
        chk(7, int'(search_done), 0);
        tick();
        chk(8, int'(search_done), 1);
        chk(9, int'(busy), 0);
        tick();
        chk(10, int'(search_done), 0);
        in_valid = 1'b0;
        repeat (3) tick();

        // Clear at beat 30 of pos 5, with a competing search_start.
        pulse_start();
        for (int p = 0; p < 5; p++)
            send_cand(pat_c[p], pat_r[p], p, pat_s[p], 1'b0, -1);
        in_valid = 1'b1; cur_pix = 32'hFFFFFFFF; ref_pix = '0;
        repeat (30) tick();
        clear = 1'b1; search_start = 1'b1;
        tick();
        clear = 1'b0; search_start = 1'b0; in_valid = 1'b0;
        chk(11, int'(busy), 0);
        repeat (6) tick();
        chk(12, strobe_cnt, 13);

        // Restart at pos 0, then async reset mid-candidate.
        pulse_start();
        send_cand(pat_c[0], pat_r[0], 0, pat_s[0], 1'b0, -1);
        in_valid = 1'b1; cur_pix = 32'hFFFFFFFF; ref_pix = '0;
        repeat (20) tick();
        reset = 1'b1;
        #1;
        chk(13, int'(sad_out), 0);
        chk(14, int'(busy), 0);
        chk(15, int'(sad_valid), 0);
        chk(16, int'(sad_position), 0);
        tick();
        reset = 1'b0;
        repeat (70) tick();
        in_valid = 1'b0;
        chk(17, int'(busy), 0);
        chk(18, strobe_cnt, 14);

        // Early termination: per-beat sum 40 reaches best_sad=100 on beat 3.
        pulse_start();
        best_sad = 16'd100;
`ifdef ME_EARLY_TERMINATE_EN
        send_cand(pat_c[7], pat_r[7], 0, 16'hFFFF, 1'b0, -1);
`else
        send_cand(pat_c[7], pat_r[7], 0, 16'd2560, 1'b0, -1);
`endif
        best_sad = 16'hFFFF;
        send_cand(pat_c[7], pat_r[7], 1, 16'd2560, 1'b0, -1);
        repeat (4) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        chk(19, exp_q.size(), 0);
        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
